// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Grants one access per cycle and returns read data with a one-cycle valid strobe.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {PREF_A = 1'b0, PREF_B = 1'b1} pref_e;

  pref_e r_pref;
  logic  r_a_rvalid;
  logic  r_b_rvalid;
  logic  w_a_win;
  logic  w_b_win;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_a_win = 1'b0;
    w_b_win = 1'b0;
    if (rst_n) begin
      if (a_req && (!b_req || r_pref == PREF_A)) w_a_win = 1'b1;
      else if (b_req)                            w_b_win = 1'b1;
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_we   = 1'b0;
    if (w_a_win) begin
      ram_addr = a_addr;
      ram_data = a_wdata;
      ram_we   = a_we;
    end else if (w_b_win) begin
      ram_addr = b_addr;
      ram_data = b_wdata;
      ram_we   = b_we;
    end
  end

  // Pointer favours the loser of each transfer; idle cycles keep it where it is.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pref     <= PREF_A;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      if (w_a_win)      r_pref <= PREF_B;
      else if (w_b_win) r_pref <= PREF_A;
      r_a_rvalid <= w_a_win && !a_we;
      r_b_rvalid <= w_b_win && !b_we;
    end
  end

  assign a_gnt    = w_a_win;
  assign b_gnt    = w_b_win;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, per-cycle vector table and a
// read-data scoreboard, plus a hand-written asynchronous-reset sequence.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [7:0] a_rdata, b_rdata, ram_addr, ram_data, ram_q;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered address, read-first.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    bit         rst_before;
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata;
    logic       e_a_gnt, e_b_gnt, e_we;
    logic [7:0] e_addr, e_data;
  } vec_t;

  typedef struct {
    bit         port_b;
    logic [7:0] data;
  } rd_t;

  vec_t       vecs[$];
  rd_t        sb[$];
  logic [7:0] shadow [256];
  int         total = 0;
  int         bad   = 0;
  int         n_a_gnt = 0;
  int         n_b_gnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic reset_pulse();
    drive_idle();
    rst_n = 1'b0;
    sb.delete();
    #2;
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic pop_read(input bit port_b, input logic [7:0] act);
    rd_t r;
    if (sb.size() == 0) begin
      check(port_b ? "b_rvalid_unexpected" : "a_rvalid_unexpected", 1, 0);
    end else begin
      r = sb.pop_front();
      check("rvalid_port", port_b, r.port_b);
      check(port_b ? "b_rdata" : "a_rdata", act, r.data);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic exp_rv_a, exp_rv_b;
    if (v.rst_before) reset_pulse();
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    #2;
    check($sformatf("v%0d_a_gnt", idx), a_gnt, v.e_a_gnt);
    check($sformatf("v%0d_b_gnt", idx), b_gnt, v.e_b_gnt);
    check($sformatf("v%0d_ram_we", idx), ram_we, v.e_we);
    check($sformatf("v%0d_ram_addr", idx), ram_addr, v.e_addr);
    check($sformatf("v%0d_ram_data", idx), ram_data, v.e_data);
    check($sformatf("v%0d_gnt_exclusive", idx), a_gnt & b_gnt, 0);
    if (a_gnt) n_a_gnt++;
    if (b_gnt) n_b_gnt++;
    exp_rv_a = v.e_a_gnt && !v.a_we;
    exp_rv_b = v.e_b_gnt && !v.b_we;
    if (exp_rv_a) sb.push_back('{1'b0, shadow[v.a_addr]});
    if (exp_rv_b) sb.push_back('{1'b1, shadow[v.b_addr]});
    if (v.e_a_gnt && v.a_we) shadow[v.a_addr] = v.a_wdata;
    if (v.e_b_gnt && v.b_we) shadow[v.b_addr] = v.b_wdata;
    @(posedge clk); #1;
    check($sformatf("v%0d_a_rvalid", idx), a_rvalid, exp_rv_a);
    check($sformatf("v%0d_b_rvalid", idx), b_rvalid, exp_rv_b);
    if (a_rvalid) pop_read(1'b0, a_rdata);
    if (b_rvalid) pop_read(1'b1, b_rdata);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'hA5;
      shadow[i] = 8'(i) ^ 8'hA5;
    end

    // Test 1: A write then read.
    vecs.push_back('{0, 1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 1,0,1,8'h10,8'h5A});
    vecs.push_back('{0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00});
    // Test 2: simultaneous first request after a fresh reset.
    vecs.push_back('{1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 1,0,0,8'h01,8'h00});
    vecs.push_back('{0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 0,1,0,8'h02,8'h00});
    // Test 3: eight cycles of read contention; each side only advances its address once granted.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] aa, ba;
      aa = 8'h40 + 8'((i + 1) / 2);
      ba = 8'h80 + 8'(i / 2);
      if (i % 2 == 0) vecs.push_back('{0, 1,0,aa,8'h00, 1,0,ba,8'h00, 1,0,0,aa,8'h00});
      else            vecs.push_back('{0, 1,0,aa,8'h00, 1,0,ba,8'h00, 0,1,0,ba,8'h00});
    end
    // Test 4: B writes, A reads it back next cycle.
    vecs.push_back('{0, 0,0,8'h00,8'h00, 1,1,8'h20,8'hC3, 0,1,1,8'h20,8'hC3});
    vecs.push_back('{0, 1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h20,8'h00});
    // Test 6: idle cycles (with unqualified we/addr), then contention won by B.
    vecs.push_back('{0, 0,1,8'h33,8'h77, 0,1,8'h44,8'h88, 0,0,0,8'h00,8'h00});
    vecs.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00});
    vecs.push_back('{0, 1,0,8'h50,8'h00, 1,0,8'h60,8'h00, 0,1,0,8'h60,8'h00});

    // Reset with requests and writes pending: nothing may be granted or written.
    rst_n = 1'b0;
    a_req = 1; a_we = 1; a_addr = 8'h11; a_wdata = 8'hEE;
    b_req = 1; b_we = 1; b_addr = 8'h22; b_wdata = 8'hDD;
    #3;
    check("por_a_gnt", a_gnt, 0);
    check("por_b_gnt", b_gnt, 0);
    check("por_ram_we", ram_we, 0);
    check("por_a_rvalid", a_rvalid, 0);
    check("por_b_rvalid", b_rvalid, 0);
    @(posedge clk); @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 4) begin n_a_gnt = 0; n_b_gnt = 0; end
      apply(vecs[i], i);
      if (i == 11) begin
        check("contention_a_count", n_a_gnt, 4);
        check("contention_b_count", n_b_gnt, 4);
      end
    end

    // Test 5: async reset during the return cycle of a granted A read.
    a_req = 1; a_we = 0; a_addr = 8'h05; b_req = 0;
    #2;
    check("t5_a_gnt", a_gnt, 1);
    @(posedge clk); #1;
    check("t5_a_rvalid_before_rst", a_rvalid, 1);
    a_req = 0;
    #1;
    rst_n = 1'b0;
    a_req = 1; a_we = 1;
    #1;
    check("t5_a_rvalid_dropped", a_rvalid, 0);
    check("t5_a_gnt_in_rst", a_gnt, 0);
    check("t5_ram_we_in_rst", ram_we, 0);
    @(posedge clk); #1;
    check("t5_a_rvalid_in_rst", a_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1; a_we = 0; a_addr = 8'h06;
    b_req = 1; b_we = 0; b_addr = 8'h07;
    #1;
    check("t5_a_rvalid_after_rst", a_rvalid, 0);
    check("t5_post_rst_a_gnt", a_gnt, 1);
    check("t5_post_rst_b_gnt", b_gnt, 0);
    check("t5_post_rst_addr", ram_addr, 8'h06);
    @(posedge clk); #1;
    check("t5_post_rst_a_rvalid", a_rvalid, 1);
    check("t5_post_rst_a_rdata", a_rdata, shadow[8'h06]);
    drive_idle();
    #2;
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (write on clock edge; address registered, read data valid the cycle after the address) between two requesters, A and B.
- Grants one access per cycle using round-robin priority.
- Drives the RAM address, write data and write enable.
- Returns read data to the winning requester with a one-cycle valid strobe.
- Sits directly in front of the RAM instance; requesters never touch the RAM pins.

Parameters:
DATA_WIDTH, 8, width of data buses (must match the RAM)
ADDR_WIDTH, 8, width of address buses (must match the RAM)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
a_req  input  1  requester A access request
a_we  input  1  A: 1=write, 0=read; qualified by a_req
a_addr  input  ADDR_WIDTH  A access address
a_wdata  input  DATA_WIDTH  A write data
a_gnt  output  1  A request accepted this cycle
a_rvalid  output  1  A read data valid
a_rdata  output  DATA_WIDTH  A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
ram_addr  output  ADDR_WIDTH  RAM address
ram_data  output  DATA_WIDTH  RAM write data
ram_we  output  1  RAM write enable
ram_q  input  DATA_WIDTH  RAM read data

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- Reset state:
  - Priority pointer = "A preferred".
  - a_rvalid = b_rvalid = 0.
  - While rst_n = 0, a_gnt, b_gnt and ram_we are forced to 0.
- Arbitration (combinational, same cycle as request):
  - Only one requester high: it is granted.
  - Both high: the preferred requester is granted.
  - Neither high: no grant, ram_we = 0, ram_addr = 0, ram_data = 0.
  - A transfer occurs when req & gnt at the rising edge. Requesters hold req, we, addr and wdata stable until granted.
- Pointer update:
  - On every transfer, the pointer moves to prefer the requester that was not granted.
  - No transfer leaves the pointer unchanged.
  - Consequence: under continuous contention, grants alternate A, B, A, B.
- RAM drive:
  - ram_addr = granted addr; ram_data = granted wdata; ram_we = granted we.
  - All combinational from the winner.
- Read return:
  - On a granted read, the requester's rvalid register is set for exactly the next cycle.
  - a_rdata and b_rdata both connect to ram_q unconditionally. Data is meaningful only while the matching rvalid is high.
  - Read latency is 1 cycle from the grant edge.
  - Back-to-back reads by the same requester give rvalid high on consecutive cycles.
- Writes:
  - No response strobe; the write takes effect at the grant edge.
  - A read of the same address granted on the next cycle returns the new data.
- Never grant both requesters in one cycle; a_gnt & b_gnt = 0 always.
- Reset mid-operation:
  - A pending rvalid is cleared immediately; that read's data is discarded.
  - The pointer returns to "A preferred".
  - The first post-reset cycle arbitrates from scratch.
- Address range: full 2**ADDR_WIDTH space, no wrap or range checks. ADDR_WIDTH and DATA_WIDTH pass straight through, with no width conversion.

Test Plan:
1. Reset then A-only: write 0x5A to addr 0x10, then read 0x10 -> a_gnt=1 on both cycles, ram_we=1 then 0; a_rvalid=1 on the cycle after the read grant with a_rdata=0x5A; b_gnt and b_rvalid stay 0.
2. Simultaneous first request after reset: A reads 0x01, B reads 0x02 -> A granted first, then B next cycle; a_rvalid then b_rvalid on consecutive cycles with the correct data.
3. Continuous contention for 8 cycles, both requesting reads -> grants strictly alternate A, B, A, B, ...; exactly 4 grants each; never both gnt high.
4. B writes 0xC3 to 0x20 while A idles, then A reads 0x20 on the next cycle -> b_gnt, ram_we=1, ram_addr=0x20; next cycle a_gnt; following cycle a_rvalid=1, a_rdata=0xC3.
5. Reset asserted asynchronously between a granted read and its return cycle -> a_rvalid drops at once and stays 0 after reset release; the next contended request grants A.
6. Idle cycles with no requests -> ram_we=0, both gnt=0, pointer unchanged; the next contention is won by the requester not most recently granted.
